prbs31_rx_checker: RTL and testbench
====================================

// Module: prbs31_rx_checker
//
// PURPOSE
// - Downstream consumer of the PRBS31 (x^31 + x^28 + 1) serial generator. Receives the
//   looped-back bit stream, self-synchronises to it and checks it bit by bit.
// - Declares lock, counts bit errors and received bits, and drops lock when the error
//   rate gets too high.
// - Sits between the chip input pad and the status/readout logic of the PRBS test path.
//
// PARAMETERS
// - ERR_W        16   width of the saturating error counter
// - BIT_W        32   width of the saturating received-bit counter
// - LOCK_GOOD    64   consecutive matching bits required in VERIFY before lock
// - WIN_LEN     256   length of the loss-of-lock window, in valid bits
// - LOSS_THRESH  16   errors within one window that force loss of lock
//
// PORTS
// - clk        in   1      clock
// - rst_n      in   1      reset, asynchronous, active-high
// - rx_bit     in   1      received PRBS bit
// - rx_valid   in   1      qualifies rx_bit; the block does nothing on cycles where it is 0
// - clr_cnt    in   1      synchronous clear of err_count and bit_count
// - locked     out  1      high while in LOCKED
// - err_pulse  out  1      one-cycle pulse per mismatched bit while LOCKED
// - err_count  out  ERR_W  saturating count of errors seen while LOCKED
// - bit_count  out  BIT_W  saturating count of valid bits seen while LOCKED
//
// BEHAVIOUR
// - Reset values: state=SEED, sr=0, locked=0, err_pulse=0, err_count=0, bit_count=0,
//   all internal counters=0.
// - Reference register sr[30:0]: sr[0] holds the newest bit.
//     - pred = sr[27] ^ sr[30].
//     - On every shift: sr <= {sr[29:0], in}.
// - All state and counter updates happen only on rx_valid=1 cycles.
// - SEED:
//     - Shift in rx_bit; seed_cnt++.
//     - After the 31st bit -> VERIFY, with good_cnt=0.
// - VERIFY:
//     - Shift in rx_bit.
//     - rx_bit==pred and sr!=0: good_cnt++.
//     - Otherwise: good_cnt=0.
//     - When good_cnt reaches LOCK_GOOD -> LOCKED on that edge; locked=1 from that edge.
//       win_cnt=0, win_err=0.
//     - An all-zero stream never locks.
// - LOCKED:
//     - Shift in pred, not rx_bit: free-running reference, so one flipped bit counts once.
//     - Each valid bit: bit_count++ and win_cnt++.
//     - rx_bit!=pred:
//         - err_pulse=1 on the next cycle only.
//         - err_count++ (saturating at all-ones).
//         - win_err++.
//     - win_cnt reaching WIN_LEN: win_cnt=0, win_err=0.
//     - win_err reaching LOSS_THRESH: -> SEED on that edge, with locked=0 and seed_cnt=0.
//       err_count and bit_count are kept.
// - Counters never wrap. bit_count saturates at 2^BIT_W-1.
// - clr_cnt=1:
//     - err_count and bit_count go to 0 on that edge.
//     - clr_cnt wins over a simultaneous increment.
//     - State, sr, and window counters are unaffected.
// - err_pulse latency is 1 clk after the errored rx_valid edge. It is 0 on all other
//   cycles, including rx_valid=0 cycles.
// - Reset mid-operation clears everything immediately (async); relock then needs a full
//   SEED+VERIFY sequence.
//
// STRUCTURE
// - Shared package prbs31_pkg:
//     - PRBS_LEN=31, TAP_A=30, TAP_B=27.
//     - State enum {SEED, VERIFY, LOCKED}, shared with the generator.
// - One sub-module, sat_counter (parameter W; ports inc, clr, q), used for err_count and
//   bit_count.
// - FSM, sr, and window logic stay in this module.
//
// TESTING
// - Clean stream from the generator (seed 1), rx_valid=1:
//     - locked rises on the 95th valid bit (31+64).
//     - err_count=0; bit_count=N-95 after N bits.
// - After lock, flip one bit:
//     - exactly one err_pulse, 1 clk later.
//     - err_count=1; locked stays 1.
// - After lock, flip 16 bits within 200 bits:
//     - locked falls on the 16th error.
//     - Relock on the 95th clean bit after that; err_count holds 16.
// - rx_bit=0 constantly for 1000 bits -> locked never asserts.
// - Clean stream with rx_valid toggling 1/0:
//     - Same lock point, counted in valid bits.
//     - No state change on rx_valid=0 cycles.
// - ERR_W=4, one error every 100 bits, for 20 errors:
//     - err_count saturates at 15; locked stays 1.
//     - clr_cnt on an error cycle -> err_count=0.
// - Assert rst_n mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs31_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prbs31_pkg
// Brief   : Shared PRBS31 (x^31 + x^28 + 1) constants, state encoding and
//           next-bit predictor, common to the generator and the rx checker.
// Revision: 1.0 - initial release
// ============================================================================
package prbs31_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  // Next PRBS bit from a reference register whose bit 0 is the newest bit.
  function automatic logic prbs_pred(input logic [PRBS_LEN-1:0] sr);
    return sr[TAP_A] ^ sr[TAP_B];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : W-bit up counter that sticks at all-ones; clr has priority.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count up on inc, hold at all-ones, clear wins over increment.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/prbs31_rx_checker.sv
`default_nettype none
// ============================================================================
// Module  : prbs31_rx_checker
// Brief   : Self-synchronising PRBS31 receive checker. Seeds a reference
//           register from the line, verifies it, then free-runs the reference
//           and counts bit errors and received bits while locked. Drops lock
//           when too many errors land inside one window.
// Revision: 1.0 - initial release
// ============================================================================
module prbs31_rx_checker
  import prbs31_pkg::*;
#(
  parameter int ERR_W       = 16,
  parameter int BIT_W       = 32,
  parameter int LOCK_GOOD   = 64,
  parameter int WIN_LEN     = 256,
  parameter int LOSS_THRESH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [BIT_W-1:0] bit_count
);

  localparam int SEED_W = $clog2(PRBS_LEN + 1);
  localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  prbs_state_t         r_state;
  prbs_state_t         w_state_next;
  logic [PRBS_LEN-1:0] r_sr;
  logic [SEED_W-1:0]   r_seed_cnt;
  logic [GOOD_W-1:0]   r_good_cnt;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [WERR_W-1:0]   r_win_err;
  logic                r_err_pulse;

  logic w_pred;
  logic w_mismatch;
  logic w_good_hit;
  logic w_seed_done;
  logic w_lock_hit;
  logic w_loss_hit;
  logic w_win_wrap;
  logic w_in_locked;
  logic w_err_inc;
  logic w_bit_inc;

  // Prediction and the per-bit decision terms shared by FSM and datapath.
  always_comb begin
    w_pred      = prbs_pred(r_sr);
    w_mismatch  = (rx_bit != w_pred);
    // An all-zero reference predicts zeros forever, so it must not count.
    w_good_hit  = (rx_bit == w_pred) && (r_sr != '0);
    w_seed_done = (r_seed_cnt == SEED_W'(PRBS_LEN - 1));
    w_lock_hit  = w_good_hit && (r_good_cnt == GOOD_W'(LOCK_GOOD - 1));
    w_loss_hit  = w_mismatch && (r_win_err == WERR_W'(LOSS_THRESH - 1));
    w_win_wrap  = (r_win_cnt == WIN_W'(WIN_LEN - 1));
    w_in_locked = (r_state == LOCKED);
    w_bit_inc   = rx_valid && w_in_locked;
    w_err_inc   = w_bit_inc && w_mismatch;
  end

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= SEED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; nothing moves on rx_valid=0 cycles.
  always_comb begin
    w_state_next = r_state;
    if (rx_valid) begin
      unique case (r_state)
        SEED:    if (w_seed_done) w_state_next = VERIFY;
        VERIFY:  if (w_lock_hit)  w_state_next = LOCKED;
        LOCKED:  if (w_loss_hit)  w_state_next = SEED;
        default: w_state_next = SEED;
      endcase
    end
  end

  // Reference register, sync counters, loss-of-lock window and error pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_sr        <= '0;
      r_seed_cnt  <= '0;
      r_good_cnt  <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (rx_valid) begin
        unique case (r_state)
          SEED: begin
            r_sr       <= {r_sr[PRBS_LEN-2:0], rx_bit};
            r_seed_cnt <= w_seed_done ? '0 : r_seed_cnt + SEED_W'(1);
            r_good_cnt <= '0;
          end
          VERIFY: begin
            r_sr <= {r_sr[PRBS_LEN-2:0], rx_bit};
            if (w_lock_hit) begin
              r_good_cnt <= '0;
              r_win_cnt  <= '0;
              r_win_err  <= '0;
            end else begin
              r_good_cnt <= w_good_hit ? r_good_cnt + GOOD_W'(1) : '0;
            end
          end
          LOCKED: begin
            // Free-running reference: a line error never corrupts it.
            r_sr        <= {r_sr[PRBS_LEN-2:0], w_pred};
            r_err_pulse <= w_mismatch;
            if (w_loss_hit) begin
              r_seed_cnt <= '0;
              r_win_cnt  <= '0;
              r_win_err  <= '0;
            end else if (w_win_wrap) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
              if (w_mismatch) r_win_err <= r_win_err + WERR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_err_inc),
    .clr   (clr_cnt),
    .q     (err_count)
  );

  sat_counter #(.W(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_bit_inc),
    .clr   (clr_cnt),
    .q     (bit_count)
  );

  assign locked    = w_in_locked;
  assign err_pulse = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_prbs31_rx_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_prbs31_rx_checker
// Brief   : Directed bench for prbs31_rx_checker. Instance a uses default
//           parameters, instance b a 4-bit error counter; both share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prbs31_rx_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_bit;
  logic        rx_valid;
  logic        clr_cnt;
  logic        locked_a, err_pulse_a;
  logic [15:0] err_count_a;
  logic [31:0] bit_count_a;
  logic        locked_b, err_pulse_b;
  logic [3:0]  err_count_b;
  logic [31:0] bit_count_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [30:0] gen_sr;

  prbs31_rx_checker dut_a (
    .clk(clk), .rst_n(rst_n), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .clr_cnt(clr_cnt), .locked(locked_a), .err_pulse(err_pulse_a),
    .err_count(err_count_a), .bit_count(bit_count_a)
  );

  prbs31_rx_checker #(.ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .clr_cnt(clr_cnt), .locked(locked_b), .err_pulse(err_pulse_b),
    .err_count(err_count_b), .bit_count(bit_count_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference generator, seed 1, newest bit in bit 0.
  task automatic gen_bit(output logic b);
    b = gen_sr[30] ^ gen_sr[27];
    gen_sr = {gen_sr[29:0], b};
  endtask

  // Drive one cycle and sample 1 time unit after the edge.
  task automatic send(input logic b, input logic v);
    rx_bit   = b;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      send(b, 1'b1);
    end
  endtask

  task automatic send_flip();
    logic b;
    gen_bit(b);
    send(~b, 1'b1);
  endtask

  task automatic do_reset();
    rst_n    = 1'b1;
    rx_bit   = 1'b0;
    rx_valid = 1'b0;
    clr_cnt  = 1'b0;
    gen_sr   = 31'd1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  initial begin
    logic b;
    int   pulses;
    logic seen;

    rst_n = 1'b0; rx_bit = 1'b0; rx_valid = 1'b0; clr_cnt = 1'b0;
    gen_sr = 31'd1;
    #1;
    do_reset();
    check("reset_locked", {31'd0, locked_a}, 32'd0);
    check("reset_pulse", {31'd0, err_pulse_a}, 32'd0);
    check("reset_err", {16'd0, err_count_a}, 32'd0);
    check("reset_bits", bit_count_a, 32'd0);

    // Clean stream: lock on the 95th bit.
    send_clean(94);
    check("clean_pre_lock", {31'd0, locked_a}, 32'd0);
    send_clean(1);
    check("clean_lock95", {31'd0, locked_a}, 32'd1);
    check("clean_bits_at_lock", bit_count_a, 32'd0);
    send_clean(205);
    check("clean_bits_300", bit_count_a, 32'd205);
    check("clean_err", {16'd0, err_count_a}, 32'd0);

    // One flipped bit.
    send_flip();
    check("flip_pulse", {31'd0, err_pulse_a}, 32'd1);
    check("flip_err", {16'd0, err_count_a}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      gen_bit(b);
      send(b, 1'b1);
      if (err_pulse_a) pulses++;
    end
    check("flip_single_pulse", pulses, 32'd0);
    check("flip_locked", {31'd0, locked_a}, 32'd1);
    check("flip_bits", bit_count_a, 32'd256);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b1;
    #1;
    check("async_locked", {31'd0, locked_a}, 32'd0);
    check("async_err", {16'd0, err_count_a}, 32'd0);
    check("async_bits", bit_count_a, 32'd0);

    // Sixteen errors within a window: lose lock, then relock.
    do_reset();
    send_clean(95);
    check("loss_locked", {31'd0, locked_a}, 32'd1);
    send_clean(10);
    for (int e = 1; e <= 16; e++) begin
      send_clean(9);
      send_flip();
      if (e == 15) check("loss_still_locked15", {31'd0, locked_a}, 32'd1);
    end
    check("loss_dropped16", {31'd0, locked_a}, 32'd0);
    check("loss_err16", {16'd0, err_count_a}, 32'd16);
    send_clean(94);
    check("relock_pre", {31'd0, locked_a}, 32'd0);
    send_clean(1);
    check("relock_95", {31'd0, locked_a}, 32'd1);
    check("relock_err_held", {16'd0, err_count_a}, 32'd16);

    // All-zero line never locks.
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      send(1'b0, 1'b1);
      seen = seen | locked_a;
    end
    check("zeros_never_lock", {31'd0, seen}, 32'd0);

    // rx_valid toggling: lock counted in valid bits only.
    do_reset();
    for (int i = 0; i < 94; i++) begin
      gen_bit(b);
      send(b, 1'b1);
      send(1'($urandom), 1'b0);
    end
    check("toggle_pre_lock", {31'd0, locked_a}, 32'd0);
    gen_bit(b);
    send(b, 1'b1);
    check("toggle_lock95", {31'd0, locked_a}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'($urandom), 1'b0);
      if (err_pulse_a) pulses++;
    end
    check("toggle_idle_bits", bit_count_a, 32'd0);
    check("toggle_idle_pulses", pulses, 32'd0);
    check("toggle_idle_locked", {31'd0, locked_a}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      gen_bit(b);
      send(b, 1'b1);
      send(1'($urandom), 1'b0);
    end
    check("toggle_bits10", bit_count_a, 32'd10);
    check("toggle_err0", {16'd0, err_count_a}, 32'd0);

    // Saturation with a 4-bit error counter.
    do_reset();
    send_clean(95);
    check("sat_locked_start", {31'd0, locked_b}, 32'd1);
    for (int e = 0; e < 20; e++) begin
      send_clean(99);
      send_flip();
    end
    check("sat_err15", {28'd0, err_count_b}, 32'd15);
    check("sat_locked", {31'd0, locked_b}, 32'd1);
    check("sat_wide_err20", {16'd0, err_count_a}, 32'd20);
    send_clean(99);
    clr_cnt = 1'b1;
    send_flip();
    clr_cnt = 1'b0;
    check("clr_err0", {28'd0, err_count_b}, 32'd0);
    check("clr_bits0", bit_count_b, 32'd0);
    check("clr_pulse", {31'd0, err_pulse_b}, 32'd1);
    send_clean(1);
    check("clr_pulse_gone", {31'd0, err_pulse_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
